audio_fifo_writer: RTL
======================

# audio_fifo_writer

Write-side producer for the audio sample FIFO whose read side the Nios II subsystem drains through its PIO ports (q, rdempty, rdfull, rdreq). Takes stereo sample pairs from the audio input path and optionally decimates them. Packs each pair into one 32-bit word and writes it to the FIFO write port in frames of FRAME_LEN words. After each frame it holds off until software has drained the FIFO, so every frame software reads is contiguous. FIFO-full events are counted, never stalled on.

## Interface
Parameters:
- FRAME_LEN, 256, words per frame (1..65535)
- DECIM, 1, keep one of every DECIM valid sample pairs (1..255)
- DROP_W, 16, width of dropped-sample counter

Ports:
- clk_clk  in  1  sole clock; FIFO write clock
- reset_reset_n  in  1  asynchronous, active-low reset
- enable  in  1  level; arms frame capture
- sample_valid  in  1  one-cycle strobe, new pair present
- sample_left  in  16  left channel, two's complement
- sample_right  in  16  right channel, two's complement
- fifo_wrfull  in  1  FIFO write-side full
- fifo_wrempty  in  1  FIFO write-side empty
- fifo_data  out  32  {sample_left, sample_right}
- fifo_wrreq  out  1  one-cycle write strobe
- frame_done  out  1  one-cycle pulse, frame complete
- overflow  out  1  sticky; set on any dropped pair
- drop_count  out  DROP_W  saturating dropped-pair count
- clear  in  1  synchronous; clears overflow and drop_count
- busy  out  1  high when state != IDLE

## Operation
- States:
  - IDLE -> FILL when enable=1; entry zeroes decim_cnt and word_cnt.
  - FILL -> IDLE when enable=0 (abort): the partial frame stays in the FIFO and no frame_done is issued.
  - FILL -> WAIT_DRAIN when word_cnt reaches FRAME_LEN.
  - WAIT_DRAIN -> IDLE when enable=0.
  - WAIT_DRAIN -> FILL when enable=1 and fifo_wrempty=1; entry zeroes decim_cnt and word_cnt.
- Decimation, in FILL only:
  - Every sample_valid advances decim_cnt modulo DECIM.
  - A pair is selected when decim_cnt==0 before the advance.
- Selected pair, fifo_wrfull=0:
  - Register fifo_data={left,right}, pulse fifo_wrreq, increment word_cnt.
- Selected pair, fifo_wrfull=1:
  - No write; the pair is dropped.
  - Set overflow; drop_count +1, saturating at 2^DROP_W-1.
  - word_cnt does not advance.
- sample_valid in IDLE or WAIT_DRAIN is ignored. It is not counted as a drop.
- frame_done pulses in the same cycle as the fifo_wrreq of the FRAME_LEN-th word.
- clear has priority over a simultaneous drop in the same cycle: the result is overflow=0 and drop_count=0.
- fifo_data holds its last value between writes.

## Timing
- Reset values: fifo_data=0, fifo_wrreq=0, frame_done=0, overflow=0, drop_count=0, busy=0; state IDLE; all counters 0.
- All outputs are registered.
- Write latency: sample_valid in cycle N -> fifo_wrreq and fifo_data valid in cycle N+1, high for exactly one cycle.
- fifo_wrfull is sampled in cycle N, the same cycle as sample_valid.
- Back-to-back sample_valid on consecutive cycles must be supported: one wrreq per selected pair, no bubbles.
- State changes on the clock edge after the condition is seen:
  - enable rising in cycle N -> busy=1 in N+1; a sample_valid in N+1 is eligible.
  - The FRAME_LEN-th write in cycle N+1 -> WAIT_DRAIN from N+2.
  - fifo_wrempty=1 in cycle M -> FILL from M+1.
- enable falling in the same cycle as a selected sample_valid: the pair is still written (wrreq in N+1), and the state goes to IDLE.
- Reset asserted mid-frame: all outputs are cleared immediately (asynchronous). Words already written remain in the FIFO.
- word_cnt width is ceil(log2(FRAME_LEN+1)); the counter never wraps.

## Test plan
- Reset, enable=1, DECIM=1, FRAME_LEN=4, six back-to-back valid pairs (0x0001/0x8000 ...) -> four wrreq pulses; first fifo_data=0x00018000; frame_done with the 4th; pairs 5-6 ignored; busy=1 in WAIT_DRAIN.
- Continue: pulse fifo_wrempty=1 for one cycle -> FILL next cycle; next valid pair written with 1-cycle latency.
- DECIM=3, nine valid pairs spaced 2 cycles apart -> writes on pairs 1, 4, 7 only; word_cnt=3.
- fifo_wrfull=1 during three selected pairs -> no wrreq; overflow=1; drop_count=3; assert clear alongside a 4th drop -> drop_count=0, overflow=0.
- DROP_W=2, five drops -> drop_count saturates at 3.
- enable dropped after 2 of 4 words, then reasserted -> IDLE with no frame_done; the new frame restarts with word_cnt=0 and needs 4 more writes for frame_done. reset_reset_n pulsed mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/audio_fifo_writer.sv
// Write-side producer for the audio sample FIFO: decimates stereo pairs, packs them into
// 32-bit words and writes them in fixed-length frames, waiting for a full drain between frames.
module audio_fifo_writer #(
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned DECIM     = 1,
    parameter int unsigned DROP_W    = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              enable,
    input  logic              sample_valid,
    input  logic [15:0]       sample_left,
    input  logic [15:0]       sample_right,
    input  logic              fifo_wrfull,
    input  logic              fifo_wrempty,
    output logic [31:0]       fifo_data,
    output logic              fifo_wrreq,
    output logic              frame_done,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count,
    input  logic              clear,
    output logic              busy
);

    localparam int unsigned WC_W = $clog2(FRAME_LEN + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [WC_W-1:0]   FRAME_LAST = WC_W'(FRAME_LEN);
    localparam logic [7:0]        DECIM_LAST = 8'(DECIM - 1);
    localparam logic [DROP_W-1:0] DROP_MAX   = {DROP_W{1'b1}};

    logic [1:0]        state_q, state_d;
    logic [7:0]        decim_q, decim_d;
    logic [WC_W-1:0]   word_q, word_d;
    logic [WC_W-1:0]   word_inc_s;
    logic [31:0]       data_q, data_d;
    logic              wrreq_q, wrreq_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              busy_q, busy_d;
    logic              capture_s;
    logic              sel_s;

    // Next-state logic: decimation, frame write, drop accounting and frame FSM.
    always_comb begin
        word_inc_s = word_q + {{(WC_W-1){1'b0}}, 1'b1};
        // Once the frame is complete the FSM still sits in FILL for one cycle; ignore pairs there.
        capture_s  = (state_q == ST_FILL) && (word_q != FRAME_LAST);
        sel_s      = capture_s && sample_valid && (decim_q == 8'd0);

        state_d = state_q;
        data_d  = data_q;
        wrreq_d = 1'b0;
        done_d  = 1'b0;
        word_d  = word_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;

        if (capture_s && sample_valid) begin
            decim_d = (decim_q == DECIM_LAST) ? 8'd0 : decim_q + 8'd1;
        end else begin
            decim_d = decim_q;
        end

        if (sel_s && !fifo_wrfull) begin
            data_d  = {sample_left, sample_right};
            wrreq_d = 1'b1;
            word_d  = word_inc_s;
            done_d  = (word_inc_s == FRAME_LAST);
        end else begin
            data_d  = data_q;
            wrreq_d = 1'b0;
        end

        // A clear in the same cycle as a drop wins.
        if (clear) begin
            ovf_d  = 1'b0;
            drop_d = {DROP_W{1'b0}};
        end else if (sel_s && fifo_wrfull) begin
            ovf_d  = 1'b1;
            drop_d = (drop_q == DROP_MAX) ? drop_q : drop_q + {{(DROP_W-1){1'b0}}, 1'b1};
        end else begin
            ovf_d  = ovf_q;
            drop_d = drop_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_FILL;
                    decim_d = 8'd0;
                    word_d  = {WC_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (word_q == FRAME_LAST) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (fifo_wrempty) begin
                    state_d = ST_FILL;
                    decim_d = 8'd0;
                    word_d  = {WC_W{1'b0}};
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= ST_IDLE;
            decim_q <= 8'd0;
            word_q  <= {WC_W{1'b0}};
            data_q  <= 32'd0;
            wrreq_q <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= {DROP_W{1'b0}};
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            decim_q <= decim_d;
            word_q  <= word_d;
            data_q  <= data_d;
            wrreq_q <= wrreq_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
            busy_q  <= busy_d;
        end
    end

    assign fifo_data  = data_q;
    assign fifo_wrreq = wrreq_q;
    assign frame_done = done_q;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;
    assign busy       = busy_q;

endmodule
